// File: rtl/psg_mix_engine.sv
// Shared PSG clock-enable divider, per-core A/B/C channel demux and a sequential
// mixer that emits a bit-replicated full-scale sample with a valid strobe.
module psg_mix_engine #(
   parameter int unsigned NUM_PSG  = 2,
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned DIV_W    = 4,
   localparam int unsigned NCH     = 3 * NUM_PSG,
   localparam int unsigned IDX_W   = $clog2(NCH),
   localparam int unsigned SUM_W   = SAMPLE_W + IDX_W
) (
   input  logic                          MCLK,
   input  logic                          RESET_L,
   input  logic [DIV_W-1:0]              DIV,
   output logic                          ENA,
   input  logic [NUM_PSG*SAMPLE_W-1:0]   AUDIO_IN,
   input  logic [NUM_PSG*2-1:0]          CHAN_IN,
   input  logic [NCH-1:0]                MUTE,
   output logic [OUT_W-1:0]              SNDO,
   output logic                          SVALID,
   output logic                          OVERRUN
);

   typedef enum logic [1:0] {StIdle, StSum, StOut} state_e;

   state_e                state_q, state_d;
   logic [DIV_W-1:0]      cnt_q, cnt_d;
   logic                  ena_q, ena_d;
   logic [SAMPLE_W-1:0]   lat_q  [NCH];
   logic [SAMPLE_W-1:0]   lat_d  [NCH];
   logic [SAMPLE_W-1:0]   snap_q [NCH];
   logic [SAMPLE_W-1:0]   snap_d [NCH];
   logic [NCH-1:0]        smute_q, smute_d;
   logic [SUM_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OUT_W-1:0]      sndo_q, sndo_d;
   logic                  svalid_q, svalid_d;
   logic                  ovr_q, ovr_d;
   logic [OUT_W-1:0]      scaled;

   // Divider: a DIV below the current count lets cnt run on to its natural wrap.
   always_comb begin
      cnt_d = (cnt_q == DIV) ? '0 : cnt_q + DIV_W'(1);
      ena_d = (cnt_q == '0);
   end

   always_comb begin
      lat_d = lat_q;
      for (int k = 0; k < int'(NUM_PSG); k++) begin
         case (CHAN_IN[2*k +: 2])
            2'd0:    lat_d[3*k]     = AUDIO_IN[k*SAMPLE_W +: SAMPLE_W];
            2'd1:    lat_d[3*k + 1] = AUDIO_IN[k*SAMPLE_W +: SAMPLE_W];
            2'd2:    lat_d[3*k + 2] = AUDIO_IN[k*SAMPLE_W +: SAMPLE_W];
            default: ;
         endcase
      end
   end

   // Fill the low bits by repeating acc from its MSB down, so full scale maps to all-ones.
   always_comb begin
      scaled = '0;
      for (int i = 0; i < int'(OUT_W); i++) begin
         scaled[int'(OUT_W) - 1 - i] = acc_q[int'(SUM_W) - 1 - (i % int'(SUM_W))];
      end
   end

   always_comb begin
      state_d  = state_q;
      snap_d   = snap_q;
      smute_d  = smute_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      sndo_d   = sndo_q;
      svalid_d = 1'b0;
      ovr_d    = ovr_q;
      case (state_q)
         StIdle: begin
            if (ena_q) begin
               snap_d  = lat_q;
               smute_d = MUTE;
               acc_d   = '0;
               idx_d   = '0;
               state_d = StSum;
            end
         end
         StSum: begin
            if (!smute_q[idx_q]) begin
               acc_d = acc_q + SUM_W'(snap_q[idx_q]);
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NCH - 1)) begin
               state_d = StOut;
            end
            if (ena_q) begin
               ovr_d = 1'b1;
            end
         end
         StOut: begin
            sndo_d   = scaled;
            svalid_d = 1'b1;
            state_d  = StIdle;
            if (ena_q) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge MCLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ena_q    <= 1'b0;
         lat_q    <= '{default: '0};
         snap_q   <= '{default: '0};
         smute_q  <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         sndo_q   <= '0;
         svalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ena_q    <= ena_d;
         lat_q    <= lat_d;
         snap_q   <= snap_d;
         smute_q  <= smute_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         sndo_q   <= sndo_d;
         svalid_q <= svalid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign ENA     = ena_q;
   assign SNDO    = sndo_q;
   assign SVALID  = svalid_q;
   assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_psg_mix_engine.sv
// Scoreboard bench for psg_mix_engine (NUM_PSG=2, SAMPLE_W=8, OUT_W=16, DIV_W=4).
module tb_psg_mix_engine;
   localparam int NCH = 6;

   logic        MCLK = 1'b0;
   logic        RESET_L;
   logic [3:0]  DIV;
   logic        ENA;
   logic [15:0] AUDIO_IN;
   logic [3:0]  CHAN_IN;
   logic [5:0]  MUTE;
   logic [15:0] SNDO;
   logic        SVALID;
   logic        OVERRUN;

   int          errors = 0;
   int          checks = 0;
   int          busy   = 0;
   int          popped = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  mdl [NCH];

   always #5 MCLK = ~MCLK;

   psg_mix_engine #(
      .NUM_PSG (2),
      .SAMPLE_W(8),
      .OUT_W   (16),
      .DIV_W   (4)
   ) dut (
      .MCLK    (MCLK),
      .RESET_L (RESET_L),
      .DIV     (DIV),
      .ENA     (ENA),
      .AUDIO_IN(AUDIO_IN),
      .CHAN_IN (CHAN_IN),
      .MUTE    (MUTE),
      .SNDO    (SNDO),
      .SVALID  (SVALID),
      .OVERRUN (OVERRUN)
   );

   // SUM_W=11, OUT_W=16: SNDO = {acc, acc[10:6]}
   function automatic logic [15:0] scale(input logic [10:0] acc);
      return {acc, 5'b00000} | 16'(acc >> 6);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Push side: an ENA seen while the mixer is idle starts a mix of the current model.
   initial begin
      forever begin
         @(negedge MCLK);
         if (!RESET_L) begin
            busy = 0;
            exp_q.delete();
         end else if (busy > 0) begin
            busy--;
         end else if (ENA) begin
            logic [10:0] acc;
            acc = '0;
            for (int i = 0; i < NCH; i++) begin
               if (!MUTE[i]) acc = acc + 11'(mdl[i]);
            end
            exp_q.push_back(scale(acc));
            busy = NCH + 1;
         end
      end
   end

   // Monitor: every SVALID pops one expectation.
   initial begin
      forever begin
         @(negedge MCLK);
         if (RESET_L && SVALID) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_svalid: got SNDO=0x%0h with no mix pending", SNDO);
            end else begin
               check("sb_sndo", 32'(SNDO), 32'(exp_q.pop_front()));
               popped++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_lat(input logic [47:0] v);
      for (int c = 0; c < 3; c++) begin
         @(posedge MCLK);
         #1;
         CHAN_IN  = {c[1:0], c[1:0]};
         AUDIO_IN = {v[8*(3+c) +: 8], v[8*c +: 8]};
         @(posedge MCLK);
         mdl[c]     = v[8*c +: 8];
         mdl[3 + c] = v[8*(3+c) +: 8];
         #1 CHAN_IN = 4'hF;
      end
   endtask

   task automatic drive_mute(input logic [5:0] m);
      @(posedge MCLK);
      #1 MUTE = m;
   endtask

   task automatic wait_ena(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge MCLK);
         seen = ENA;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_ena_timeout: got no ENA required one within 40 cycles", name);
      end
   endtask

   task automatic run_mix(input string name, input logic [15:0] exp_v, input bit toggle);
      time t0;
      bit  seen = 1'b0;
      wait_ena(name);
      t0 = $time;
      if (toggle) begin
         drive_mute(6'h3F);
         drive_mute(6'h00);
         drive_mute(6'h02);
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge MCLK);
         seen = SVALID;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_sv_timeout: got no SVALID required one within 20 cycles", name);
      end else begin
         check({name, "_sndo"}, 32'(SNDO), 32'(exp_v));
         check({name, "_latency"}, 32'((($time - t0) / 10)), 32'(NCH + 2));
      end
   endtask

   initial begin
      int n0;
      int hi;
      RESET_L  = 1'b0;
      DIV      = 4'd7;
      AUDIO_IN = '0;
      CHAN_IN  = 4'hF;
      MUTE     = '0;
      for (int i = 0; i < NCH; i++) mdl[i] = '0;
      repeat (3) @(posedge MCLK);
      #1;
      check("rst_ena", 32'(ENA), 0);
      check("rst_sndo", 32'(SNDO), 0);
      check("rst_svalid", 32'(SVALID), 0);
      check("rst_overrun", 32'(OVERRUN), 0);
      RESET_L = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge MCLK);
         check($sformatf("ena_div7_c%0d", i), 32'(ENA), 32'(i % 8 == 1));
      end

      set_lat({8'd3, 8'd2, 8'd1, 8'd30, 8'd20, 8'd10});
      run_mix("mix66", 16'h0841, 1'b0);
      set_lat({6{8'hFF}});
      run_mix("mixff", 16'hBF57, 1'b0);
      set_lat('0);
      run_mix("mix0", 16'h0000, 1'b0);
      set_lat({8'd3, 8'd2, 8'd1, 8'd30, 8'd20, 8'd10});
      drive_mute(6'b000010);
      run_mix("mute_b", 16'h05C0, 1'b0);
      run_mix("mute_toggle", 16'h05C0, 1'b1);
      check("no_overrun_div7", 32'(OVERRUN), 0);

      // ENA period 4 against an 8-cycle mix: every other ENA is dropped.
      drive_mute(6'h00);
      @(posedge MCLK);
      #1 DIV = 4'd3;
      n0 = popped;
      repeat (60) @(negedge MCLK);
      check("div3_mix_count_ge4", 32'(popped - n0 >= 4), 1);
      check("div3_mix_count_le8", 32'(popped - n0 <= 8), 1);
      check("div3_overrun", 32'(OVERRUN), 1);
      check("div3_sndo", 32'(SNDO), 32'h0841);

      @(posedge MCLK);
      #1 DIV = 4'd0;
      repeat (2) @(posedge MCLK);
      wait_ena("div0");
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge MCLK);
         if (ENA) hi++;
      end
      check("ena_div0_continuous", 32'(hi), 10);

      @(posedge MCLK);
      #1 DIV = 4'd7;
      wait_ena("pre_reset");
      repeat (3) @(posedge MCLK);
      #1 RESET_L = 1'b0;
      for (int i = 0; i < NCH; i++) mdl[i] = '0;
      #1;
      check("midrst_ena", 32'(ENA), 0);
      check("midrst_sndo", 32'(SNDO), 0);
      check("midrst_svalid", 32'(SVALID), 0);
      check("midrst_overrun", 32'(OVERRUN), 0);
      repeat (2) @(posedge MCLK);
      #1 RESET_L = 1'b1;
      hi = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge MCLK);
         check($sformatf("post_rst_ena_c%0d", i), 32'(ENA), 32'(i == 1));
         if (SVALID) hi++;
      end
      check("post_rst_no_svalid", 32'(hi), 0);
      @(negedge MCLK);
      check("post_rst_first_svalid", 32'(SVALID), 1);
      check("post_rst_first_sndo", 32'(SNDO), 0);

      repeat (4) @(negedge MCLK);
      check("sb_total_mixes_ge10", 32'(popped >= 10), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
